// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds architectural HI/LO, computes a result
// at issue and commits it after a fixed busy interval so the hazard unit can stall.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_start,
    output logic        E_busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [31:0]     hi_reg;
    logic [31:0]     lo_reg;
    logic [31:0]     phi_reg;
    logic [31:0]     plo_reg;

    logic            is_md;
    logic            is_mult;
    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]     quo_u;
    logic [31:0]     rem_u;
    logic            div_ovf;
    logic [31:0]     res_hi;
    logic [31:0]     res_lo;

    assign is_md   = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU) ||
                     (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
    assign is_mult = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);

    assign E_busy  = (state_reg == ST_BUSY);
    assign E_start = is_md && !E_busy;
    assign E_HI    = hi_reg;
    assign E_LO    = lo_reg;

    always_comb begin
        E_MDU_out = 32'd0;
        if (E_MDUOp == OP_MFHI)
            E_MDU_out = hi_reg;
        else if (E_MDUOp == OP_MFLO)
            E_MDU_out = lo_reg;
    end

    // Sign-extend to 64 bits so the low 64 bits of the unsigned product are the signed product.
    assign prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    assign a_s     = $signed(E_A);
    assign b_s     = $signed(E_B);
    assign div_ovf = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);

    always_comb begin
        quo_s = 32'sd0;
        rem_s = 32'sd0;
        quo_u = 32'd0;
        rem_u = 32'd0;
        if (E_B != 32'd0) begin
            quo_u = E_A / E_B;
            rem_u = E_A % E_B;
            if (!div_ovf) begin
                quo_s = a_s / b_s;
                rem_s = a_s % b_s;
            end else begin
                quo_s = 32'sh8000_0000;
                rem_s = 32'sd0;
            end
        end
    end

    // Divide by zero reloads the current HI/LO so the commit is a no-op.
    always_comb begin
        res_hi = hi_reg;
        res_lo = lo_reg;
        case (E_MDUOp)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (E_B != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OP_DIVU: begin
                if (E_B != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: begin
                res_hi = hi_reg;
                res_lo = lo_reg;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            phi_reg   <= 32'd0;
            plo_reg   <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (E_start) begin
                        phi_reg   <= res_hi;
                        plo_reg   <= res_lo;
                        cnt_reg   <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state_reg <= ST_BUSY;
                    end else if (E_MDUOp == OP_MTHI) begin
                        hi_reg <= E_A;
                    end else if (E_MDUOp == OP_MTLO) begin
                        lo_reg <= E_A;
                    end
                end
                ST_BUSY: begin
                    // Any MD op arriving here is dropped; pending state is left alone.
                    if (cnt_reg == CW'(1)) begin
                        hi_reg    <= phi_reg;
                        lo_reg    <= plo_reg;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: expected HI/LO results are queued at issue and
// compared at the commit edge; busy duration is measured per operation.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_start;
    logic        E_busy;
    logic [31:0] E_MDU_out;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDUOp   (E_MDUOp),
        .E_A       (E_A),
        .E_B       (E_B),
        .E_start   (E_start),
        .E_busy    (E_busy),
        .E_MDU_out (E_MDU_out),
        .E_HI      (E_HI),
        .E_LO      (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present an MD op, check E_start, queue the expectation,
    // then advance to the next negedge with the op removed.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input int n);
        exp_t e;
        E_MDUOp = op;
        E_A     = a;
        E_B     = b;
        #1;
        check({tag, "_start"}, {63'd0, E_start}, 64'd1);
        e.tag = tag; e.hi = hi; e.lo = lo; e.n = n;
        sb_q.push_back(e);
        @(negedge clk);
        E_MDUOp = 4'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
    endtask

    // Counts negedges with busy high (including the current one) and compares
    // the committed HI/LO against the head of the scoreboard.
    task automatic wait_commit(input int already);
        exp_t e;
        int   cyc;
        cyc = already;
        while (E_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_busy_cycles"}, 64'(cyc), 64'(e.n));
            check({e.tag, "_hi"}, {32'd0, E_HI}, {32'd0, e.hi});
            check({e.tag, "_lo"}, {32'd0, E_LO}, {32'd0, e.lo});
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        longint      ps;
        logic [63:0] pu;

        reset   = 1'b0;
        E_MDUOp = 4'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, E_busy}, 64'd0);
        check("rst_hilo", {E_HI, E_LO}, 64'd0);
        E_MDUOp = 4'd5;
        #1;
        check("rst_mfhi", {32'd0, E_MDU_out}, 64'd0);
        E_MDUOp = 4'd0;
        reset = 1'b1;
        @(negedge clk);

        // mult -2 * 3, with mfhi/mflo probed mid-operation
        issue("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
        E_MDUOp = 4'd5;
        #1;
        check("mfhi_busy", {32'd0, E_MDU_out}, 64'd0);
        E_MDUOp = 4'd6;
        #1;
        check("mflo_busy", {32'd0, E_MDU_out}, 64'd0);
        E_MDUOp = 4'd0;
        wait_commit(0);
        E_MDUOp = 4'd5;
        #1;
        check("mfhi_after", {32'd0, E_MDU_out}, {32'd0, 32'hFFFF_FFFF});
        E_MDUOp = 4'd6;
        #1;
        check("mflo_after", {32'd0, E_MDU_out}, {32'd0, 32'hFFFF_FFFA});
        E_MDUOp = 4'd0;

        issue("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC);
        wait_commit(0);
        issue("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
        wait_commit(0);
        issue("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, DC);
        wait_commit(0);
        issue("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DC);
        wait_commit(0);

        // mthi / mtlo on consecutive cycles
        E_MDUOp = 4'd7;
        E_A     = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", {32'd0, E_HI}, {32'd0, 32'h1234_5678});
        check("mthi_busy", {63'd0, E_busy}, 64'd0);
        E_MDUOp = 4'd8;
        E_A     = 32'h9ABC_DEF0;
        @(negedge clk);
        E_MDUOp = 4'd0;
        E_A     = 32'd0;
        check("mtlo_lo", {32'd0, E_LO}, {32'd0, 32'h9ABC_DEF0});
        check("mtlo_busy", {63'd0, E_busy}, 64'd0);

        issue("div0", 4'd3, 32'd77, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, DC);
        wait_commit(0);

        // ops presented while busy must be ignored; then back-to-back mult
        issue("div_ign", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, DC);
        E_MDUOp = 4'd1;
        E_A     = 32'd3;
        E_B     = 32'd4;
        #1;
        check("ign_mult_start", {63'd0, E_start}, 64'd0);
        @(negedge clk);
        E_MDUOp = 4'd8;
        E_A     = 32'hDEAD_BEEF;
        #1;
        check("ign_mtlo_start", {63'd0, E_start}, 64'd0);
        @(negedge clk);
        E_MDUOp = 4'd0;
        E_A     = 32'd0;
        E_B     = 32'd0;
        wait_commit(2);
        issue("b2b_mult", 4'd1, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, MC);
        wait_commit(0);

        // a few random multiplies against an independent 64-bit model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i[0]) begin
                pu = 64'(ra) * 64'(rb);
                issue("rand_multu", 4'd2, ra, rb, pu[63:32], pu[31:0], MC);
            end else begin
                ps = longint'(signed'(ra)) * longint'(signed'(rb));
                issue("rand_mult", 4'd1, ra, rb, ps[63:32], ps[31:0], MC);
            end
            wait_commit(0);
        end

        // reset in the middle of a div discards the pending result
        issue("div_rst", 4'd4, 32'd1000, 32'd3, 32'd1, 32'd333, DC);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, E_busy}, 64'd0);
        check("rst_mid_hilo", {E_HI, E_LO}, 64'd0);
        void'(sb_q.pop_front());
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_busy", {63'd0, E_busy}, 64'd0);
        check("post_rst_hilo", {E_HI, E_LO}, 64'd0);

        // first edge after release accepts a start
        issue("post_rst_mult", 4'd2, 32'd9, 32'd9, 32'd0, 32'd81, MC);
        wait_commit(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit with architectural HI/LO registers for the P6 pipeline. It sits immediately downstream of the D→E pipeline register and consumes the E-stage forwarded operands and the decoded MD operation. It models multi-cycle latency with a busy counter so that the hazard unit can stall the D stage. It drives the mfhi/mflo result onto the E-stage result path.

## Interface
- MULT_CYCLES, 5, busy duration for mult/multu (≥1)
- DIV_CYCLES, 10, busy duration for div/divu (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- E_MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- E_A  in  32  forwarded rs value
- E_B  in  32  forwarded rt value
- E_start  out  1  combinational: E_MDUOp ∈ {1..4} and !E_busy
- E_busy  out  1  registered: operation in flight
- E_MDU_out  out  32  combinational: HI if op 5, LO if op 6, else 0
- E_HI  out  32  architectural HI
- E_LO  out  32  architectural LO

## Operation
- State:
  - HI, LO.
  - Pending result registers pHI, pLO.
  - Down-counter cnt, wide enough for max(MULT_CYCLES, DIV_CYCLES).
  - busy.
- Reset (async, reset=0): HI=LO=pHI=pLO=0, cnt=0, busy=0. Outputs: E_busy=0, E_HI=E_LO=0, E_MDU_out=0.
- IDLE (busy=0), at a rising edge with E_start=1:
  - Compute the result from E_A/E_B into pHI/pLO.
  - Set cnt=MULT_CYCLES or DIV_CYCLES, and busy=1.
- BUSY (busy=1), each rising edge:
  - cnt decrements.
  - At the edge where cnt==1: HI←pHI, LO←pLO, busy←0, cnt←0.
- mult: signed 64-bit product of E_A and E_B; pHI=[63:32], pLO=[31:0].
- multu: same as mult, but the product is unsigned.
- div (signed):
  - pLO = quotient truncated toward zero; pHI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives pLO=0x80000000, pHI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (E_B=0):
  - pHI/pLO are loaded with the current HI/LO, so commit leaves them unchanged.
  - Full DIV_CYCLES busy still applies.
- mthi/mtlo, when not busy: HI←E_A (op 7) or LO←E_A (op 8) at the next edge, with no busy.
- MD op while busy: any op 1–4 or 7–8 issued while busy=1 is ignored; pending state is untouched. The hazard unit guarantees this never happens architecturally, and the block stays safe if it does.
- mfhi/mflo: purely combinational read of the current HI/LO.
  - While busy, this returns the pre-commit value.
  - Stalling on busy|E_start is the hazard unit's job.
- Commit edge: HI/LO update and busy falls on the same edge. A new op presented in the following cycle sees busy=0 and may start.

## Timing
- Start sampled at edge T0 → E_busy=1 from T0 until edge T0+N (N=MULT_CYCLES or DIV_CYCLES), so busy is high for exactly N cycles.
- New HI/LO are visible after edge T0+N.
- E_start and E_MDU_out are combinational from E_MDUOp, busy, HI and LO; there is no added latency.
- Back-to-back: the earliest second start is at edge T0+N+1, i.e. the op is presented in the first cycle with busy=0.
- Reset asserted mid-operation: busy, cnt and all registers clear asynchronously, and the pending result is discarded. After deassertion the unit is IDLE with HI=LO=0.
- Reset release: the first rising edge with reset=1 may accept a start.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3:
  - E_start=1 in the issue cycle.
  - busy high for exactly 5 cycles.
  - After commit, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
  - mfhi/mflo during busy return 0.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
- div cases:
  - A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - divu with the same operands → LO=0x7FFFFFFC, HI=1.
- mthi/mtlo and divide-by-zero:
  - mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO update on the next edge, busy stays 0.
  - Then div with B=0 → busy for 10 cycles, HI/LO unchanged.
- While busy from a div:
  - Present mult and mtlo → both ignored, E_start=0.
  - Commit yields the div result only.
  - mult issued in the first non-busy cycle starts normally.
- Start a div, then assert reset at busy cycle 4:
  - busy drops immediately; HI=LO=0.
  - No late commit occurs after reset release.
